// File: rtl/elevator_ctrl_n.sv
// elevator_ctrl_n: N-floor SCAN elevator controller with timed travel and door dwell
module elevator_ctrl_n #(
    parameter int FLOORS     = 8,
    parameter int FW         = 3,
    parameter int TRAVEL_CYC = 4,
    parameter int DOOR_CYC   = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [FLOORS-1:0] req,
    output logic [FW-1:0]     floor,
    output logic [1:0]        dir,
    output logic [1:0]        state,
    output logic              door_open,
    output logic              moving,
    output logic [FLOORS-1:0] pending
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MOVE = 2'd1;
    localparam logic [1:0] S_DOOR = 2'd2;
    localparam logic [1:0] D_IDLE = 2'b00;
    localparam logic [1:0] D_UP   = 2'b01;
    localparam logic [1:0] D_DN   = 2'b10;
    localparam int TW = (TRAVEL_CYC > 1) ? $clog2(TRAVEL_CYC) : 1;
    localparam int DW = (DOOR_CYC > 1) ? $clog2(DOOR_CYC) : 1;
    localparam logic [TW-1:0] T_LAST = TW'(TRAVEL_CYC - 1);
    localparam logic [DW-1:0] D_LAST = DW'(DOOR_CYC - 1);

    logic [FW-1:0]     floor_q, floor_d, step_floor;
    logic [1:0]        dir_q, dir_d, state_q, state_d;
    logic [TW-1:0]     tcnt_q, tcnt_d;
    logic [DW-1:0]     dcnt_q, dcnt_d;
    logic [FLOORS-1:0] pending_q, pending_d, pend_or, clr;
    logic              above, below, go_up, go_dn;

    // Next-state logic: SCAN decisions use latched requests; arrival checks also see this cycle's req
    always_comb begin
        pend_or = pending_q | req;
        above = 1'b0;
        below = 1'b0;
        for (int i = 0; i < FLOORS; i++) begin
            if (pending_q[i] && FW'(i) > floor_q) above = 1'b1;
            if (pending_q[i] && FW'(i) < floor_q) below = 1'b1;
        end
        step_floor = (dir_q == D_DN) ? floor_q - 1'b1 : floor_q + 1'b1;
        // Going down keeps going down while targets remain below; otherwise up has priority
        go_up = (dir_q == D_DN) ? (above && !below) : above;
        go_dn = (dir_q == D_DN) ? below : (below && !above);
        floor_d = floor_q;
        dir_d   = dir_q;
        state_d = state_q;
        tcnt_d  = tcnt_q;
        dcnt_d  = dcnt_q;
        clr     = '0;
        case (state_q)
            S_IDLE: begin
                if (pending_q[floor_q]) begin
                    state_d = S_DOOR;
                    clr     = FLOORS'(1) << floor_q;
                end else if (above || below) begin
                    state_d = S_MOVE;
                    dir_d   = above ? D_UP : D_DN;
                end
            end
            S_MOVE: begin
                if (tcnt_q == T_LAST) begin
                    tcnt_d  = '0;
                    floor_d = step_floor;
                    if (pend_or[step_floor]) begin
                        state_d = S_DOOR;
                        clr     = FLOORS'(1) << step_floor;
                    end
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end
            S_DOOR: begin
                clr = FLOORS'(1) << floor_q;
                if (dcnt_q == D_LAST) begin
                    dcnt_d  = '0;
                    state_d = (go_up || go_dn) ? S_MOVE : S_IDLE;
                    dir_d   = go_up ? D_UP : (go_dn ? D_DN : D_IDLE);
                end else begin
                    dcnt_d = dcnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        pending_d = pend_or & ~clr;
    end

    // State registers with immediate asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            floor_q   <= '0;
            dir_q     <= D_IDLE;
            state_q   <= S_IDLE;
            tcnt_q    <= '0;
            dcnt_q    <= '0;
            pending_q <= '0;
        end else begin
            floor_q   <= floor_d;
            dir_q     <= dir_d;
            state_q   <= state_d;
            tcnt_q    <= tcnt_d;
            dcnt_q    <= dcnt_d;
            pending_q <= pending_d;
        end
    end

    assign floor     = floor_q;
    assign dir       = dir_q;
    assign state     = state_q;
    assign door_open = (state_q == S_DOOR);
    assign moving    = (state_q == S_MOVE);
    assign pending   = pending_q;
endmodule

// File: tb/tb_elevator_ctrl_n.sv
// tb_elevator_ctrl_n: scenario tasks plus random traffic against a behavioural SCAN model
module tb_elevator_ctrl_n;
    localparam int F = 8;
    localparam int T = 4;
    localparam int D = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  req;
    logic [2:0]  floor;
    logic [1:0]  dir, state;
    logic        door_open, moving;
    logic [7:0]  pending;
    logic [15:0] req16;
    logic [3:0]  floor16;
    logic [1:0]  dir16, state16;
    logic        door16, moving16;
    logic [15:0] pending16;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model: floor as int, direction as -1/0/+1, phase 0 idle / 1 travelling / 2 door, countdown timer
    int         m_f, m_d, m_ph, m_left;
    logic [7:0] m_p;

    elevator_ctrl_n #(.FLOORS(8), .FW(3), .TRAVEL_CYC(4), .DOOR_CYC(3)) dut (
        .clk(clk), .rst(rst), .req(req), .floor(floor), .dir(dir), .state(state),
        .door_open(door_open), .moving(moving), .pending(pending));

    elevator_ctrl_n #(.FLOORS(16), .FW(4), .TRAVEL_CYC(4), .DOOR_CYC(3)) dut16 (
        .clk(clk), .rst(rst), .req(req16), .floor(floor16), .dir(dir16), .state(state16),
        .door_open(door16), .moving(moving16), .pending(pending16));

    always #5 clk = ~clk;

    function automatic bit any_above(input logic [7:0] p, input int f);
        for (int i = f + 1; i < F; i++) if (p[i]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit any_below(input logic [7:0] p, input int f);
        for (int i = 0; i < f; i++) if (p[i]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [1:0] dir_code(input int d);
        return (d == 1) ? 2'b01 : ((d == -1) ? 2'b10 : 2'b00);
    endfunction

    task automatic model_reset();
        m_f = 0; m_d = 0; m_ph = 0; m_left = 0; m_p = '0;
    endtask

    task automatic model_step(input logic [7:0] r);
        logic [7:0] po, clr;
        bit up, dn;
        int nd;
        po = m_p | r;
        clr = '0;
        case (m_ph)
            0: begin
                if (m_p[m_f]) begin m_ph = 2; m_left = D; clr[m_f] = 1'b1; end
                else if (any_above(m_p, m_f)) begin m_ph = 1; m_d = 1; m_left = T; end
                else if (any_below(m_p, m_f)) begin m_ph = 1; m_d = -1; m_left = T; end
            end
            1: begin
                m_left--;
                if (m_left == 0) begin
                    m_f += m_d;
                    if (po[m_f]) begin m_ph = 2; m_left = D; clr[m_f] = 1'b1; end
                    else m_left = T;
                end
            end
            default: begin
                clr[m_f] = 1'b1;
                m_left--;
                if (m_left == 0) begin
                    up = any_above(m_p, m_f);
                    dn = any_below(m_p, m_f);
                    if (m_d == -1) nd = dn ? -1 : (up ? 1 : 0);
                    else nd = up ? 1 : (dn ? -1 : 0);
                    m_d = nd;
                    m_ph = (nd == 0) ? 0 : 1;
                    m_left = T;
                end
            end
        endcase
        m_p = po & ~clr;
    endtask

    // One clock: drive req, let both DUT and model take the edge, return at the falling edge
    task automatic tick(input logic [7:0] r);
        req = r;
        @(posedge clk);
        model_step(r);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; req = '0; req16 = '0;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    // Leave the current door stop (if any) and run until the next door opens
    task automatic wait_door(output bit ok);
        bit left_door = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (state !== 2'd2) begin left_door = 1'b1; break; end
            tick(8'h00);
        end
        if (!left_door) return;
        for (int i = 0; i < 200; i++) begin
            if (state === 2'd2) begin ok = 1'b1; break; end
            tick(8'h00);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; req = '0; req16 = '0;
        @(negedge clk);
        n_checks++;
        if ({floor, dir, state, door_open, moving, pending} !== 17'h0) begin
            n_errors++;
            $display("FAIL reset_state: got floor=%0d dir=%b state=%0d door=%b mov=%b pend=%h, want all zero",
                     floor, dir, state, door_open, moving, pending);
        end
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_same_floor();
        do_reset();
        tick(8'h01);
        n_checks++;
        if (pending !== 8'h01 || state !== 2'd0) begin
            n_errors++;
            $display("FAIL same_floor_latch: got pend=%h state=%0d, want pend=01 state=0", pending, state);
        end
        tick(8'h00);
        n_checks++;
        if (state !== 2'd2 || door_open !== 1'b1 || pending !== 8'h00 || dir !== 2'b00) begin
            n_errors++;
            $display("FAIL same_floor_door: got state=%0d door=%b pend=%h dir=%b, want 2 1 00 00",
                     state, door_open, pending, dir);
        end
        tick(8'h00);
        tick(8'h00);
        n_checks++;
        if (door_open !== 1'b1) begin
            n_errors++;
            $display("FAIL same_floor_dwell: got door=%b on third door cycle, want 1", door_open);
        end
        tick(8'h00);
        n_checks++;
        if (state !== 2'd0 || door_open !== 1'b0 || dir !== 2'b00) begin
            n_errors++;
            $display("FAIL same_floor_idle: got state=%0d door=%b dir=%b, want 0 0 00", state, door_open, dir);
        end
    endtask

    task automatic test_single_trip();
        do_reset();
        tick(8'h08);
        tick(8'h00);
        n_checks++;
        if (moving !== 1'b1 || dir !== 2'b01 || floor !== 3'd0) begin
            n_errors++;
            $display("FAIL trip_start: got mov=%b dir=%b floor=%0d, want 1 01 0", moving, dir, floor);
        end
        for (int k = 1; k <= 3; k++) begin
            repeat (T) tick(8'h00);
            n_checks++;
            if (floor !== 3'(k) || state !== ((k == 3) ? 2'd2 : 2'd1)) begin
                n_errors++;
                $display("FAIL trip_step%0d: got floor=%0d state=%0d, want floor=%0d", k, floor, state, k);
            end
        end
        tick(8'h00);
        tick(8'h00);
        n_checks++;
        if (door_open !== 1'b1 || pending !== 8'h00) begin
            n_errors++;
            $display("FAIL trip_dwell: got door=%b pend=%h, want 1 00", door_open, pending);
        end
        tick(8'h00);
        n_checks++;
        if (state !== 2'd0 || dir !== 2'b00 || floor !== 3'd3) begin
            n_errors++;
            $display("FAIL trip_idle: got state=%0d dir=%b floor=%0d, want 0 00 3", state, dir, floor);
        end
    endtask

    task automatic test_mid_stop();
        bit ok;
        do_reset();
        tick(8'h20);
        tick(8'h00);
        tick(8'h04);
        wait_door(ok);
        n_checks++;
        if (!ok || floor !== 3'd2 || pending !== 8'h20 || dir !== 2'b01) begin
            n_errors++;
            $display("FAIL mid_stop_first: got ok=%b floor=%0d pend=%h dir=%b, want 1 2 20 01", ok, floor, pending, dir);
        end
        wait_door(ok);
        n_checks++;
        if (!ok || floor !== 3'd5 || pending !== 8'h00) begin
            n_errors++;
            $display("FAIL mid_stop_second: got ok=%b floor=%0d pend=%h, want 1 5 00", ok, floor, pending);
        end
    endtask

    task automatic test_scan_reverse();
        bit ok;
        do_reset();
        tick(8'h20);
        wait_door(ok);
        n_checks++;
        if (!ok || floor !== 3'd5 || dir !== 2'b01) begin
            n_errors++;
            $display("FAIL scan_at5: got ok=%b floor=%0d dir=%b, want 1 5 01", ok, floor, dir);
        end
        tick(8'h82);
        n_checks++;
        if (pending !== 8'h82 || state !== 2'd2) begin
            n_errors++;
            $display("FAIL scan_latch: got pend=%h state=%0d, want 82 2", pending, state);
        end
        wait_door(ok);
        n_checks++;
        if (!ok || floor !== 3'd7 || dir !== 2'b01 || pending !== 8'h02) begin
            n_errors++;
            $display("FAIL scan_top: got ok=%b floor=%0d dir=%b pend=%h, want 1 7 01 02", ok, floor, dir, pending);
        end
        wait_door(ok);
        n_checks++;
        if (!ok || floor !== 3'd1 || dir !== 2'b10 || pending !== 8'h00) begin
            n_errors++;
            $display("FAIL scan_reverse: got ok=%b floor=%0d dir=%b pend=%h, want 1 1 10 00", ok, floor, dir, pending);
        end
    endtask

    task automatic test_two_sided();
        bit ok;
        bit idle = 1'b0;
        do_reset();
        tick(8'h08);
        wait_door(ok);
        for (int i = 0; i < 50; i++) begin
            if (state === 2'd0) begin idle = 1'b1; break; end
            tick(8'h00);
        end
        n_checks++;
        if (!ok || !idle || floor !== 3'd3) begin
            n_errors++;
            $display("FAIL two_sided_setup: got ok=%b idle=%b floor=%0d, want 1 1 3", ok, idle, floor);
        end
        tick(8'h42);
        tick(8'h00);
        n_checks++;
        if (dir !== 2'b01 || moving !== 1'b1) begin
            n_errors++;
            $display("FAIL two_sided_upfirst: got dir=%b mov=%b, want 01 1", dir, moving);
        end
        wait_door(ok);
        n_checks++;
        if (!ok || floor !== 3'd6) begin
            n_errors++;
            $display("FAIL two_sided_first: got ok=%b floor=%0d, want 1 6", ok, floor);
        end
        wait_door(ok);
        n_checks++;
        if (!ok || floor !== 3'd1 || dir !== 2'b10) begin
            n_errors++;
            $display("FAIL two_sided_second: got ok=%b floor=%0d dir=%b, want 1 1 10", ok, floor, dir);
        end
    endtask

    task automatic test_random();
        logic [7:0]  r;
        logic [16:0] got, exp;
        do_reset();
        for (int c = 0; c < 800; c++) begin
            r = ($urandom_range(0, 5) == 0) ? 8'($urandom) : 8'h00;
            tick(r);
            got = {floor, dir, state, door_open, moving, pending};
            exp = {3'(m_f), dir_code(m_d), 2'(m_ph), m_ph == 2, m_ph == 1, m_p};
            n_checks++;
            if (got !== exp) begin
                n_errors++;
                $display("FAIL random_cycle%0d: got floor=%0d dir=%b state=%0d door=%b mov=%b pend=%h, want floor=%0d dir=%b state=%0d pend=%h",
                         c, floor, dir, state, door_open, moving, pending, m_f, dir_code(m_d), m_ph, m_p);
            end
        end
    endtask

    task automatic test_async_reset();
        bit found = 1'b0;
        int n = 0;
        bit arrived = 1'b0;
        do_reset();
        tick(8'h08);
        for (int i = 0; i < 100; i++) begin
            if (floor === 3'd2 && moving === 1'b1) begin found = 1'b1; break; end
            tick(8'h00);
        end
        tick(8'h00);
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if (!found || {floor, dir, state, door_open, moving, pending} !== 17'h0) begin
            n_errors++;
            $display("FAIL async_reset: got found=%b floor=%0d dir=%b state=%0d mov=%b pend=%h, want all zero",
                     found, floor, dir, state, moving, pending);
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        req16 = 16'h8000;
        tick(8'h00);
        req16 = 16'h0000;
        for (int i = 0; i < 200; i++) begin
            if (state16 === 2'd2) begin arrived = 1'b1; break; end
            tick(8'h00);
            n++;
        end
        n_checks++;
        if (!arrived || floor16 !== 4'd15 || door16 !== 1'b1 || pending16 !== 16'h0 || n != 1 + 15 * T) begin
            n_errors++;
            $display("FAIL top_floor16: got arrived=%b floor=%0d door=%b pend=%h cycles=%0d, want 1 15 1 0000 %0d",
                     arrived, floor16, door16, pending16, n, 1 + 15 * T);
        end
    endtask

    initial begin
        test_reset();
        test_same_floor();
        test_single_trip();
        test_mid_stop();
        test_scan_reverse();
        test_two_sided();
        test_random();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/elevator_ctrl_n.md
# elevator_ctrl_n

Parametrised N-floor elevator controller: the next-generation replacement for the fixed 5-floor (ground to 4th) controller. It latches floor requests into a pending register and serves them with a SCAN (continue-in-direction, then reverse) policy. It models per-floor travel time and a timed door-open dwell. It sits between the floor/car call-button logic and the motor/door drivers and status display.

## Interface
- FLOORS, 8: number of floors, indexed 0..FLOORS-1 (0 = ground); legal range 2..16.
- FW, 3: floor index width; must satisfy 2^FW >= FLOORS.
- TRAVEL_CYC, 4: clock cycles to move one floor; must be >= 1.
- DOOR_CYC, 3: clock cycles the door stays open per stop; must be >= 1.

Ports:
- clk  in  1  single clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req  in  FLOORS  request bits; req[i]=1 in a cycle registers a call for floor i; level or pulse both accepted.
- floor  out  FW  current car floor.
- dir  out  2  00 idle, 01 up, 10 down; 11 never driven.
- state  out  2  0 IDLE, 1 MOVE, 2 DOOR; 3 never driven.
- door_open  out  1  high exactly while state=DOOR.
- moving  out  1  high exactly while state=MOVE.
- pending  out  FLOORS  latched outstanding requests.

## Operation
- Reset, asynchronous and immediate: floor=0, dir=00, state=IDLE, door_open=0, moving=0, pending=0, travel and door counters=0.
- Pending update each edge: pending <= (pending | req) & ~clr.
  - clr is the one-hot of the stop floor on the edge entering DOOR, and of the current floor throughout DOOR.
  - Clear beats set. req[floor] during DOOR is dropped and does not extend the dwell.
- above = any pending bit with index > floor; below = any pending bit with index < floor.
- IDLE transitions:
  - If pending[floor]: go to DOOR, dir stays 00.
  - Else if above: go to MOVE with dir=01. Up wins when above and below are both set.
  - Else if below: go to MOVE with dir=10.
  - Else hold.
- MOVE:
  - The travel counter counts 0..TRAVEL_CYC-1.
  - On the terminal count, floor steps by ±1 per dir and the counter resets to 0.
  - On that same edge: if (pending|req)[new floor], go to DOOR; otherwise stay in MOVE.
  - MOVE is entered only with a target ahead. Targets are never cleared except at a stop, so floor never passes 0 or FLOORS-1.
- DOOR:
  - The door counter counts 0..DOOR_CYC-1. On the terminal count, choose the next state.
  - Continue: if requests exist ahead in the current dir, go to MOVE with the same dir.
  - Reverse: else if requests exist in the opposite direction, go to MOVE with dir reversed. If dir=00, up has priority.
  - Else go to IDLE with dir=00.
- dir holds its value in DOOR, so SCAN order is preserved across stops.
- All outputs are registered; there is no combinational path from req to outputs.

## Timing
- req sampled at edge E sets pending at E.
- From IDLE with a request for a different floor: state=MOVE at E+1; the first floor step lands at E+1+TRAVEL_CYC.
- From IDLE with a request for the current floor: state=DOOR and pending cleared at E+1; door_open lasts DOOR_CYC cycles.
- A request for floor k, registered before the car arrives at k while moving toward k, stops the car at k. A request arriving on the arrival edge also stops it, because the check uses pending|req.
- A request for the floor just passed waits for the reverse sweep.
- Total trip in cycles from IDLE at floor a to the door at floor b (no intermediate stops): 1 + |b-a|*TRAVEL_CYC after pending is set.
- Reset asserted mid-MOVE or mid-DOOR forces the reset values without waiting for a clock edge. Operation resumes on the first edge after rst deasserts.

## Test plan
- Reset; at floor 0, pulse req[0] for one cycle -> next edge state=2, door_open=1 for 3 cycles, pending=0, then state=0, dir=00.
- Pulse req[3] from IDLE at floor 0 -> moving=1, dir=01; floor reads 1,2,3 at 4-cycle intervals; DOOR at 3 for 3 cycles; then IDLE with dir=00.
- From floor 0, req[5]; then req[2] while between floors 0 and 1 -> the car stops at 2 (door 3 cycles), then stops at 5; pending bits clear in that order.
- Car at floor 5 with the door open and dir=01; assert req[7] and req[1] -> serves 7 first (dir=01), then reverses with dir=10 and serves 1.
- IDLE at floor 3; req[1] and req[6] in the same cycle -> dir=01 first, reaching 6 before 1.
- Assert rst asynchronously mid-MOVE between floors 2 and 3 -> floor=0, state=0, dir=00, pending=0 immediately; with FLOORS=16 and FW=4, floor 15 is reached without overflow.
